// File: rtl/spi_master.sv
// Single-clock SPI initiator: serialises a 10-bit command MSB first and, on
// read-data commands, captures an 8-bit reply after a turnaround gap.
module spi_master #(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] cmd_word,
    output logic       busy,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       MISO,
    output logic       MOSI,
    output logic       SS_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SHIFT_OUT,
        S_TURN,
        S_SHIFT_IN,
        S_DESELECT
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
    localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] sh_q, sh_d;
    logic       is_rd_q, is_rd_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            is_rd_q    <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            is_rd_q    <= is_rd_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SELECT;
                    cnt_d   = '0;
                end
            end
            S_SELECT: begin
                state_d = S_SHIFT_OUT;
                cnt_d   = '0;
            end
            S_SHIFT_OUT: begin
                if (cnt_q == 4'd9) begin
                    state_d = is_rd_q ? S_TURN : S_DESELECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = S_SHIFT_IN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SHIFT_IN: begin
                if (cnt_q == 4'd7) begin
                    state_d = S_DESELECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DESELECT: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so pins change on the same
    // edge as the state; MISO is therefore sampled on edges entering SHIFT_IN.
    always_comb begin
        sh_d    = sh_q;
        is_rd_d = is_rd_q;
        if (state_q == S_IDLE && state_d == S_SELECT) begin
            sh_d    = cmd_word;
            is_rd_d = (cmd_word[9:8] == 2'b11);
        end else if (state_q == S_SHIFT_OUT && state_d == S_SHIFT_OUT) begin
            sh_d = {sh_q[8:0], 1'b0};
        end else if (state_d == S_SHIFT_IN) begin
            sh_d = {sh_q[8:0], MISO};
        end

        ss_n_d     = (state_d == S_IDLE) || (state_d == S_DESELECT);
        mosi_d     = (state_d == S_SHIFT_OUT) ? sh_d[9] : 1'b0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_q == S_DESELECT) && (state_d == S_IDLE);
        rd_valid_d = done_d && is_rd_q;
        rd_data_d  = rd_valid_d ? sh_q[7:0] : rd_data_q;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign MOSI     = mosi_q;
    assign SS_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: checks pin timing edge by edge and models a
// tiny SPI slave/RAM by decoding captured MOSI frames.
module tb_spi_master;

    localparam int T = 2;
    localparam int G = 1;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] cmd_word;
    logic       busy;
    logic       done;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       miso;
    logic       mosi;
    logic       ss_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [256];
    logic [7:0] slv_addr;
    logic [9:0] bits;

    spi_master #(.TURNAROUND(T), .IDLE_GAP(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd_word (cmd_word),
        .busy     (busy),
        .done     (done),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .MISO     (miso),
        .MOSI     (mosi),
        .SS_n     (ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame starting now; on return we are just after the done edge.
    task automatic run_frame(input logic [9:0] cmd, input logic [7:0] miso_byte,
                             input int poke_at, input logic [9:0] poke_cmd,
                             output logic [9:0] got);
        logic rd;
        int   last;
        rd   = (cmd[9:8] == 2'b11);
        last = rd ? 18 + T : 10;
        got  = '0;
        start    = 1'b1;
        cmd_word = cmd;
        tick;
        start    = 1'b0;
        cmd_word = 10'($urandom);
        chk("sel_ss_n", 10'(ss_n), 10'd0);
        chk("sel_busy", 10'(busy), 10'd1);
        chk("sel_mosi", 10'(mosi), 10'd0);
        for (int k = 0; k < 10; k++) begin
            if (1 + k == poke_at) begin
                start    = 1'b1;
                cmd_word = poke_cmd;
            end else begin
                start = 1'b0;
            end
            tick;
            got[9-k] = mosi;
            chk("shift_ss_n", 10'(ss_n), 10'd0);
            chk("shift_done", 10'(done), 10'd0);
        end
        start = 1'b0;
        for (int e = 11; e <= last + 1 + G; e++) begin
            if (rd && e >= 11 + T && e <= 18 + T)
                miso = miso_byte[7 - (e - 11 - T)];
            else
                miso = 1'($urandom_range(0, 1));
            tick;
            if (e <= last) begin
                chk("tail_ss_n_low", 10'(ss_n), 10'd0);
                chk("tail_mosi", 10'(mosi), 10'd0);
            end else if (e < last + 1 + G) begin
                chk("gap_ss_n", 10'(ss_n), 10'd1);
                chk("gap_busy", 10'(busy), 10'd1);
                chk("gap_done", 10'(done), 10'd0);
            end else begin
                chk("done_pulse", 10'(done), 10'd1);
                chk("done_busy", 10'(busy), 10'd0);
                chk("done_ss_n", 10'(ss_n), 10'd1);
                chk("done_rd_valid", 10'(rd_valid), 10'(rd));
                if (rd) chk("done_rd_data", 10'(rd_data), 10'(miso_byte));
            end
        end
    endtask

    // Minimal slave model: applies a decoded command to the RAM/address latch.
    task automatic slave_apply(input logic [9:0] f);
        case (f[9:8])
            2'b00, 2'b10: slv_addr = f[7:0];
            2'b01:        mem[slv_addr] = f[7:0];
            default:      ;
        endcase
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd_word = '0; miso = 1'b0; slv_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        tick; tick;
        chk("rst_ss_n", 10'(ss_n), 10'd1);
        chk("rst_mosi", 10'(mosi), 10'd0);
        chk("rst_busy", 10'(busy), 10'd0);
        chk("rst_done", 10'(done), 10'd0);
        chk("rst_rd_valid", 10'(rd_valid), 10'd0);
        chk("rst_rd_data", 10'(rd_data), 10'h00);
        rst = 1'b0;
        tick;

        // Write address 0x0A5: MOSI 0,0,1,0,1,0,0,1,0,1
        run_frame(10'h0A5, 8'h00, -1, '0, bits);
        chk("wa_mosi_stream", bits, 10'h0A5);

        // Write data then rd-addr, second start in the done cycle
        tick;
        run_frame(10'h1FF, 8'h00, -1, '0, bits);
        chk("wd_mosi_stream", bits, 10'h1FF);
        run_frame(10'h2A5, 8'h00, -1, '0, bits);
        chk("ra_mosi_stream", bits, 10'h2A5);

        // Read data with MISO 1,0,1,1,0,0,1,0
        tick;
        run_frame(10'h300, 8'hB2, -1, '0, bits);
        chk("rd_mosi_stream", bits, 10'h300);
        tick;
        chk("rd_valid_pulse_end", 10'(rd_valid), 10'd0);
        chk("rd_data_hold", 10'(rd_data), 10'h0B2);

        // End-to-end through the slave model
        run_frame(10'h03C, 8'h00, -1, '0, bits);
        slave_apply(bits);
        chk("e2e_hold_after_write", 10'(rd_data), 10'h0B2);
        run_frame(10'h15A, 8'h00, -1, '0, bits);
        slave_apply(bits);
        run_frame(10'h23C, 8'h00, -1, '0, bits);
        slave_apply(bits);
        run_frame(10'h300, mem[slv_addr], -1, '0, bits);
        chk("e2e_rd_data", 10'(rd_data), 10'h05A);

        // start while busy is ignored
        tick;
        run_frame(10'h0A5, 8'h00, 5, 10'h3FF, bits);
        chk("busy_start_stream", bits, 10'h0A5);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("busy_start_single_done", 10'(done), 10'd0);
            chk("busy_start_idle", 10'(busy), 10'd0);
        end

        // Reset during SHIFT_OUT bit 4 (cmd[5]=1 so MOSI is high there)
        start = 1'b1; cmd_word = 10'h1E3;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("mid_bit4_mosi", 10'(mosi), 10'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_ss_n", 10'(ss_n), 10'd1);
        chk("mid_rst_mosi", 10'(mosi), 10'd0);
        chk("mid_rst_busy", 10'(busy), 10'd0);
        chk("mid_rst_done", 10'(done), 10'd0);
        chk("mid_rst_rd_data", 10'(rd_data), 10'h000);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("mid_rst_no_done", 10'(done), 10'd0);
        end
        run_frame(10'h2C7, 8'h00, -1, '0, bits);
        chk("post_rst_stream", bits, 10'h2C7);
        run_frame(10'h300, 8'h6D, -1, '0, bits);
        chk("post_rst_read_stream", bits, 10'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
